regfile_wr_arbiter: RTL and testbench
=====================================

# regfile_wr_arbiter

Shares the single write port of `register_file` between two writers: the in-order pipeline WB stage and a long-latency result port (e.g. MUL/DIV) that returns results out of order. Holds a 32-entry busy scoreboard and drives the ID-stage stall, so that no instruction reads or overwrites a register whose long-latency result is still pending. Sits between the WB stage, the long-latency unit and `top_decode`. Its `rf_wr_*` outputs replace the direct `wb_wr_*` connection.

## Interface
- `DEPTH`, 2: number of pending long-latency result entries (FIFO depth, 1–4).
- `STARVE_LIMIT`, 4: number of consecutive cycles the FIFO head may be blocked by WB before the arbiter forces a hold.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `wb_wr_en` / `wb_wr_addr` / `wb_wr_data` in 1/5/32: pipeline writeback request.
- `lq_valid` in 1, `lq_ready` out 1, `lq_addr` in 5, `lq_data` in 32: long-latency result handshake (valid/ready).
- `id_valid` in 1: the ID stage holds a live instruction.
- `id_rs1`, `id_rs2`, `id_rd` in 5 each: register addresses of the ID instruction.
- `id_rd_wr` in 1: the ID instruction writes `id_rd`.
- `id_long` in 1: the ID instruction issues to the long-latency unit.
- `id_stall` out 1: freezes IF/ID and inserts a bubble.
- `pipe_hold` out 1: freezes the WB stage for one cycle (anti-starvation).
- `rf_wr_en` / `rf_wr_addr` / `rf_wr_data` out 1/5/32: register_file write port.
- `busy_mask` out 32: scoreboard; bit 0 is always 0.
- `lq_count` out 3: number of FIFO entries.

## Operation
- **FIFO.**
  - `lq_ready` = !rst && (`lq_count` < DEPTH).
  - An entry is accepted when `lq_valid` && `lq_ready`. An accepted entry with `lq_addr`=0 is discarded and not enqueued.
  - Push and pop may occur in the same cycle. `lq_ready` is computed from the count before any pop, so a full FIFO does not accept even while it pops.
- **Port select**, evaluated in priority order each cycle:
  1. If `pipe_hold`=1 and the FIFO is non-empty: the FIFO head is written and popped; `wb_wr_en` is ignored, because the pipeline re-presents it the next cycle.
  2. Otherwise, if `wb_wr_en`=1 and `wb_wr_addr`≠0: the WB request is written, and the head is blocked.
  3. Otherwise, if the FIFO is non-empty: the head is written and popped.
  4. Otherwise: `rf_wr_en`=0.
  - A WB request to x0 never drives the port and does not block the head.
- **Scoreboard.**
  - `issue` = `id_valid` && `id_long` && `id_rd_wr` && `id_rd`≠0 && !`id_stall`. On `issue`, `busy[id_rd]` is set.
  - A pop clears `busy[head.addr]`.
  - If a set and a clear hit the same register in the same cycle, the set wins.
  - `busy[0]` is tied to 0.
- **Stall.**
  - `eff_busy[r]` = `busy[r]` && !(a pop writes r this cycle). The register file forwards the write, so the stall drops in the pop cycle itself.
  - `id_stall` = `id_valid` && ((`id_rs1`≠0 && `eff_busy[id_rs1]`) || (`id_rs2`≠0 && `eff_busy[id_rs2]`) || (`id_rd_wr` && `id_rd`≠0 && `eff_busy[id_rd]`)).
  - The last term (WAW) guarantees at most one outstanding long result per register. It also guarantees that WB never writes a busy register.
- **Starvation.**
  - `starve_cnt` increments in each cycle the head is blocked by WB. It resets to 0 on any pop or when the FIFO is empty.
  - When `starve_cnt` reaches STARVE_LIMIT, `pipe_hold` is registered high for exactly one cycle, and `starve_cnt` is cleared.
- **Protocol errors.** The following are protocol errors with undefined behaviour, and the bench must never drive them: `lq_addr` not busy at acceptance; `lq_valid` dropping before acceptance.

## Timing
- **Reset.** In the cycle after `rst` is sampled high:
  - FIFO empty, `lq_count`=0, `busy_mask`=0, `starve_cnt`=0, `pipe_hold`=0.
  - While `rst`=1: `lq_ready`=0, `rf_wr_en`=0, `id_stall`=0.
- **Reset mid-operation.** All pending entries are dropped and the scoreboard is cleared. Nothing is written to the register file.
- **Latencies.**
  - Port select and `id_stall` are combinational from current state and inputs.
  - `busy`, the FIFO and `pipe_hold` update on posedge.
  - Long-latency result: minimum 1 cycle from acceptance to `rf_wr_en` (accepted at edge N, written in cycle N+1). It is never written in the acceptance cycle.
  - Issue to busy: `busy[rd]` is visible the cycle after `issue`.
  - Stall release: the dependent instruction's `id_stall` is 0 during the pop cycle.
- **Ordering.** The FIFO retires entries strictly in acceptance order.
- **Worst case.** Continuous WB traffic delays the head by at most STARVE_LIMIT+1 cycles.

## Test plan
- **Reset.** Drive reset with all inputs active → `rf_wr_en`=0, `lq_ready`=0, `id_stall`=0. After release: `busy_mask`=0, `lq_count`=0, `lq_ready`=1.
- **Issue and return.** Issue MUL x5 (`id_long`, `id_rd`=5), then in the next cycle present ADD reading rs1=x5 → `busy_mask`=0x20 and `id_stall`=1. Then return `lq_addr`=5, `lq_data`=0xDEADBEEF with no WB traffic → write x5=0xDEADBEEF one cycle after acceptance; `id_stall`=0 in that cycle; `busy_mask`=0 afterwards.
- **Priority.** Return x7 with data 0x11, then drive `wb_wr_en` x3=0x22 in the next cycle → port writes x3 first, then x7 the cycle after. `starve_cnt` reaches 1 and then clears.
- **Starvation.** FIFO holds x9 while WB writes every cycle → after 4 blocked cycles, `pipe_hold`=1 for one cycle. In that cycle the port writes x9 and `wb_wr_en` is ignored.
- **Full and WAW.**
  - With DEPTH=2 and two entries queued, `lq_ready`=0; a third `lq_valid` is held until one entry pops.
  - ID issuing `id_rd`=5 while x5 is busy gives `id_stall`=1.
  - `lq_addr`=0 is accepted and never written.
- **Mid-operation reset.** Assert reset with 2 FIFO entries queued and x4/x6 busy → no write occurs, and `busy_mask`=0 and `lq_count`=0 in the next cycle.

Source files
------------

// File: rtl/regfile_wr_arbiter_if.sv
// Long-latency result handshake into the register-file write arbiter.
// The master presents a result; the slave accepts it on valid && ready.
interface regfile_wr_arbiter_if;
  logic        lq_valid;
  logic        lq_ready;
  logic [4:0]  lq_addr;
  logic [31:0] lq_data;

  modport master (
    output lq_valid,
    output lq_addr,
    output lq_data,
    input  lq_ready
  );

  modport slave (
    input  lq_valid,
    input  lq_addr,
    input  lq_data,
    output lq_ready
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between WB and a long-latency
// result FIFO; keeps the busy scoreboard and drives the ID stall.
module regfile_wr_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_wr_en,
  input  logic [4:0]  wb_wr_addr,
  input  logic [31:0] wb_wr_data,
  regfile_wr_arbiter_if.slave lq,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_rd_wr,
  input  logic        id_long,
  output logic        id_stall,
  output logic        pipe_hold,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic [31:0] busy_mask,
  output logic [2:0]  lq_count
);

  localparam logic [1:0] LAST = 2'(DEPTH - 1);
  localparam logic [2:0] FULL = 3'(DEPTH);
  localparam logic [7:0] SL   = 8'(STARVE_LIMIT);

  logic [4:0]  q_addr [4];
  logic [31:0] q_data [4];
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;
  logic [2:0]  count;
  logic [31:0] busy;
  logic [7:0]  starve_cnt;

  logic        empty;
  logic        wb_ok;
  logic        pop;
  logic        blocked;
  logic        push;
  logic        issue;
  logic [4:0]  head_addr;
  logic [31:0] clr_mask;
  logic [31:0] set_mask;
  logic [31:0] eff_busy;

  assign empty     = (count == 3'd0);
  assign head_addr = q_addr[rd_ptr];
  assign wb_ok     = wb_wr_en && (wb_wr_addr != 5'd0);

  // A pending hold lets the head through regardless of WB.
  assign pop     = !rst && !empty && (pipe_hold || !wb_ok);
  assign blocked = !rst && !empty && !pipe_hold && wb_ok;

  assign lq.lq_ready = !rst && (count < FULL);
  assign push = lq.lq_valid && lq.lq_ready
             && (lq.lq_addr != 5'd0);

  assign rf_wr_en   = pop || (!rst && wb_ok);
  assign rf_wr_addr = pop ? head_addr : wb_wr_addr;
  assign rf_wr_data = pop ? q_data[rd_ptr] : wb_wr_data;

  assign clr_mask = pop ? (32'd1 << head_addr) : 32'd0;
  assign eff_busy = busy & ~clr_mask;

  always_comb begin
    id_stall = 1'b0;
    if (!rst && id_valid) begin
      id_stall = ((id_rs1 != 5'd0) && eff_busy[id_rs1])
              || ((id_rs2 != 5'd0) && eff_busy[id_rs2])
              || (id_rd_wr && (id_rd != 5'd0)
                  && eff_busy[id_rd]);
    end
  end

  assign issue = id_valid && id_long && id_rd_wr
              && (id_rd != 5'd0) && !id_stall;
  assign set_mask = issue ? (32'd1 << id_rd) : 32'd0;

  assign busy_mask = busy;
  assign lq_count  = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= 2'd0;
      wr_ptr     <= 2'd0;
      count      <= 3'd0;
      busy       <= 32'd0;
      starve_cnt <= 8'd0;
      pipe_hold  <= 1'b0;
    end else begin
      if (push) begin
        q_addr[wr_ptr] <= lq.lq_addr;
        q_data[wr_ptr] <= lq.lq_data;
        wr_ptr <= (wr_ptr == LAST) ? 2'd0 : wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? 2'd0 : rd_ptr + 2'd1;
      end
      count <= count + {2'd0, push} - {2'd0, pop};
      busy  <= ((busy & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
      pipe_hold <= 1'b0;
      if (pop || empty) begin
        starve_cnt <= 8'd0;
      end else if (blocked) begin
        if (starve_cnt + 8'd1 >= SL) begin
          starve_cnt <= 8'd0;
          pipe_hold  <= 1'b1;
        end else begin
          starve_cnt <= starve_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed checks for regfile_wr_arbiter: reset, issue/return,
// priority, starvation hold, full FIFO, WAW and mid-operation reset.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_wr_en;
  logic [4:0]  wb_wr_addr;
  logic [31:0] wb_wr_data;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_rd_wr;
  logic        id_long;
  logic        id_stall;
  logic        pipe_hold;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [31:0] busy_mask;
  logic [2:0]  lq_count;

  int n_chk  = 0;
  int n_pass = 0;

  regfile_wr_arbiter_if lqi ();

  regfile_wr_arbiter #(
    .DEPTH(2),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb_wr_en(wb_wr_en),
    .wb_wr_addr(wb_wr_addr),
    .wb_wr_data(wb_wr_data),
    .lq(lqi.slave),
    .id_valid(id_valid),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_rd(id_rd),
    .id_rd_wr(id_rd_wr),
    .id_long(id_long),
    .id_stall(id_stall),
    .pipe_hold(pipe_hold),
    .rf_wr_en(rf_wr_en),
    .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data),
    .busy_mask(busy_mask),
    .lq_count(lq_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic idle();
    wb_wr_en     = 1'b0;
    wb_wr_addr   = 5'd0;
    wb_wr_data   = 32'd0;
    lqi.lq_valid = 1'b0;
    lqi.lq_addr  = 5'd0;
    lqi.lq_data  = 32'd0;
    id_valid     = 1'b0;
    id_rs1       = 5'd0;
    id_rs2       = 5'd0;
    id_rd        = 5'd0;
    id_rd_wr     = 1'b0;
    id_long      = 1'b0;
  endtask

  // Start of a cycle: just past the edge, inputs then set by caller.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic id_long_op(input logic [4:0] rd);
    idle();
    id_valid = 1'b1;
    id_long  = 1'b1;
    id_rd_wr = 1'b1;
    id_rd    = rd;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_wr_en   = 1'b1;
    wb_wr_addr = a;
    wb_wr_data = d;
  endtask

  task automatic lq(input logic [4:0] a, input logic [31:0] d);
    lqi.lq_valid = 1'b1;
    lqi.lq_addr  = a;
    lqi.lq_data  = d;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    // Reset with every input active.
    wb(5'd3, 32'h33);
    lq(5'd5, 32'h55);
    id_valid = 1'b1;
    id_long  = 1'b1;
    id_rd_wr = 1'b1;
    id_rd    = 5'd5;
    id_rs1   = 5'd5;
    cyc();
    cyc();
    settle();
    chk("rst_rf_wr_en", 32'(rf_wr_en), 32'd0);
    chk("rst_lq_ready", 32'(lqi.lq_ready), 32'd0);
    chk("rst_id_stall", 32'(id_stall), 32'd0);
    chk("rst_pipe_hold", 32'(pipe_hold), 32'd0);
    cyc();
    rst = 1'b0;
    idle();
    settle();
    chk("rel_busy", busy_mask, 32'd0);
    chk("rel_count", 32'(lq_count), 32'd0);
    chk("rel_lq_ready", 32'(lqi.lq_ready), 32'd1);

    // Issue MUL x5, dependent ADD stalls, result returns.
    cyc(); id_long_op(5'd5); id_rs1 = 5'd1; id_rs2 = 5'd2; settle();
    chk("mul_issue_stall", 32'(id_stall), 32'd0);
    cyc(); idle();
    id_valid = 1'b1; id_rs1 = 5'd5; id_rd = 5'd6; id_rd_wr = 1'b1;
    settle();
    chk("mul_busy", busy_mask, 32'h20);
    chk("add_stall", 32'(id_stall), 32'd1);
    cyc(); lq(5'd5, 32'hDEADBEEF); settle();
    chk("acc_ready", 32'(lqi.lq_ready), 32'd1);
    chk("acc_no_write", 32'(rf_wr_en), 32'd0);
    chk("acc_stall", 32'(id_stall), 32'd1);
    cyc(); lqi.lq_valid = 1'b0; settle();
    chk("ret_count", 32'(lq_count), 32'd1);
    chk("ret_wr_en", 32'(rf_wr_en), 32'd1);
    chk("ret_addr", 32'(rf_wr_addr), 32'd5);
    chk("ret_data", rf_wr_data, 32'hDEADBEEF);
    chk("ret_stall", 32'(id_stall), 32'd0);
    cyc(); idle(); settle();
    chk("ret_busy_clr", busy_mask, 32'd0);
    chk("ret_count0", 32'(lq_count), 32'd0);
    chk("ret_idle_wr", 32'(rf_wr_en), 32'd0);

    // WB has priority over the FIFO head.
    cyc(); id_long_op(5'd7); settle();
    cyc(); idle(); lq(5'd7, 32'h11); settle();
    chk("pri_busy", busy_mask, 32'h80);
    cyc(); idle(); wb(5'd3, 32'h22); settle();
    chk("pri_wb_addr", 32'(rf_wr_addr), 32'd3);
    chk("pri_wb_data", rf_wr_data, 32'h22);
    chk("pri_count", 32'(lq_count), 32'd1);
    cyc(); idle(); settle();
    chk("pri_lq_en", 32'(rf_wr_en), 32'd1);
    chk("pri_lq_addr", 32'(rf_wr_addr), 32'd7);
    chk("pri_lq_data", rf_wr_data, 32'h11);
    cyc(); settle();
    chk("pri_busy_clr", busy_mask, 32'd0);
    chk("pri_hold", 32'(pipe_hold), 32'd0);

    // Starvation: WB every cycle, head x9 forced out after 4.
    cyc(); id_long_op(5'd9); settle();
    cyc(); idle(); lq(5'd9, 32'h99); settle();
    for (int i = 0; i < 4; i++) begin
      cyc(); idle(); wb(5'(10 + i), 32'(i)); settle();
      chk($sformatf("stv_hold%0d", i), 32'(pipe_hold), 32'd0);
      chk($sformatf("stv_wb%0d", i), 32'(rf_wr_addr), 32'(10 + i));
    end
    cyc(); idle(); wb(5'd14, 32'hE); settle();
    chk("stv_hold", 32'(pipe_hold), 32'd1);
    chk("stv_addr", 32'(rf_wr_addr), 32'd9);
    chk("stv_data", rf_wr_data, 32'h99);
    cyc(); settle();
    chk("stv_hold_off", 32'(pipe_hold), 32'd0);
    chk("stv_wb_again", 32'(rf_wr_addr), 32'd14);
    chk("stv_count", 32'(lq_count), 32'd0);
    chk("stv_busy", busy_mask, 32'd0);

    // Full FIFO, WAW stall, x0 result discarded.
    cyc(); id_long_op(5'd4); settle();
    cyc(); id_long_op(5'd6); settle();
    chk("full_busy4", busy_mask, 32'h10);
    cyc(); id_long_op(5'd4); lq(5'd4, 32'h44);
    wb(5'd20, 32'h2020); settle();
    chk("waw_busy", busy_mask, 32'h50);
    chk("waw_stall", 32'(id_stall), 32'd1);
    chk("full_wb20", 32'(rf_wr_addr), 32'd20);
    cyc(); idle(); lq(5'd6, 32'h66); wb(5'd21, 32'h21); settle();
    chk("full_ready1", 32'(lqi.lq_ready), 32'd1);
    cyc(); idle(); lq(5'd0, 32'hBAD); wb(5'd22, 32'h22); settle();
    chk("full_count", 32'(lq_count), 32'd2);
    chk("full_ready0", 32'(lqi.lq_ready), 32'd0);
    cyc(); wb_wr_en = 1'b0; settle();
    chk("full_pop_ready", 32'(lqi.lq_ready), 32'd0);
    chk("full_pop4", 32'(rf_wr_addr), 32'd4);
    chk("full_data4", rf_wr_data, 32'h44);
    cyc(); settle();
    chk("full_acc_x0", 32'(lqi.lq_ready), 32'd1);
    chk("full_pop6", 32'(rf_wr_addr), 32'd6);
    chk("full_data6", rf_wr_data, 32'h66);
    cyc(); idle(); settle();
    chk("x0_count", 32'(lq_count), 32'd0);
    chk("x0_no_wr", 32'(rf_wr_en), 32'd0);
    chk("x0_busy", busy_mask, 32'd0);
    cyc(); settle();
    chk("x0_no_wr2", 32'(rf_wr_en), 32'd0);

    // Reset with two entries pending.
    cyc(); id_long_op(5'd4); settle();
    cyc(); id_long_op(5'd6); settle();
    cyc(); idle(); lq(5'd4, 32'h44); wb(5'd20, 32'h1); settle();
    cyc(); idle(); lq(5'd6, 32'h66); wb(5'd21, 32'h2); settle();
    cyc(); idle(); wb(5'd22, 32'h3); settle();
    chk("mr_count2", 32'(lq_count), 32'd2);
    chk("mr_busy", busy_mask, 32'h50);
    rst = 1'b1;
    settle();
    chk("mr_no_wr", 32'(rf_wr_en), 32'd0);
    chk("mr_ready", 32'(lqi.lq_ready), 32'd0);
    cyc(); rst = 1'b0; idle(); settle();
    chk("mr_count0", 32'(lq_count), 32'd0);
    chk("mr_busy0", busy_mask, 32'd0);
    chk("mr_no_wr2", 32'(rf_wr_en), 32'd0);
    cyc(); settle();
    chk("mr_no_wr3", 32'(rf_wr_en), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
